jk_q_edge_monitor: RTL
======================

# jk_q_edge_monitor

Downstream monitor for the JK flip-flop output. It consumes `Q` on the same clock and reports every rising and falling transition as a one-cycle pulse. It also keeps a saturating transition count, flags a stuck output after a programmable number of idle cycles, and flags toggle mode when J=K=1 makes Q alternate on consecutive cycles. All outputs are registered.

## Interface
- `CNT_W`, default 8: width of `edge_count`.
- `STUCK_LIMIT`, default 4: enabled cycles without a transition before `stuck` asserts (≥1, < 2^CNT_W).
- `TOGGLE_RUN`, default 3: consecutive enabled cycles with a transition before `toggling` asserts (≥1).

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; highest priority.
- `enable` in 1: monitor enable; when 0, all state is frozen.
- `clear` in 1: synchronous soft clear of counters and flags; priority below `reset`, above everything else.
- `q_in` in 1: Q from the JK flip-flop, same clock domain; no synchronizer.
- `rise` out 1: one-cycle pulse for a 0→1 transition.
- `fall` out 1: one-cycle pulse for a 1→0 transition.
- `edge_count` out CNT_W: total transitions, saturating at 2^CNT_W−1.
- `stuck` out 1: level; no transition for STUCK_LIMIT enabled cycles.
- `toggling` out 1: level; Q alternated on TOGGLE_RUN consecutive enabled cycles.
- `q_level` out 1: last sampled valid level of q_in.

## Operation
- FSM states: INIT (no valid prior sample), LOW, HIGH.
- Reset: state=INIT. All outputs are 0: rise, fall, edge_count, stuck, toggling, q_level. Internal `stable_cnt` and `run_cnt` are 0.
- INIT with enable=1:
  - Capture q_in into q_level.
  - Go to LOW or HIGH. No edge is reported, no counters change.
- LOW with enable=1:
  - If q_in=1: rise=1, edge_count+1 (saturating), state→HIGH, q_level=1.
  - Else: rise=0.
- HIGH with enable=1: mirror image of LOW, producing `fall`.
- Transition cycle (enabled, edge seen):
  - stable_cnt=0, stuck=0.
  - run_cnt increments, saturating at TOGGLE_RUN.
  - toggling=1 when the new run_cnt equals TOGGLE_RUN.
- Non-transition cycle (enabled, state LOW or HIGH):
  - run_cnt=0, toggling=0.
  - stable_cnt increments, saturating at STUCK_LIMIT.
  - stuck=1 when the new stable_cnt equals STUCK_LIMIT.
  - stuck stays 1 until the next transition, clear, or reset.
- enable=0:
  - rise=fall=0; everything else holds its value and q_in is ignored.
  - On re-enable, q_in is compared against the held state. A level changed while disabled is reported as one edge.
- clear=1 (with reset=0):
  - edge_count, stable_cnt, run_cnt, stuck, toggling, rise and fall go to 0; state→INIT.
  - q_level holds.
  - Applies regardless of `enable`. An edge present in the same cycle is discarded.
- Saturation: edge_count never wraps. At 2^CNT_W−1, pulses still fire but the count holds.

## Timing
- Latency: if q_in differs from the state at rising edge t, rise/fall is high during the cycle after t (one cycle only). edge_count and q_level update at the same edge t.
- First enabled edge after reset or clear only initializes the FSM. The earliest edge is reported at the second enabled edge.
- Maximum rate: one transition reported per cycle; alternating q_in every cycle yields continuous alternating rise/fall pulses.
- stuck asserts at the edge that completes STUCK_LIMIT consecutive enabled non-transition cycles.
- toggling asserts at the edge of the TOGGLE_RUN-th consecutive transition and drops at the first non-transition enabled edge.
- Reset mid-operation: all outputs are 0 after the reset edge, including a pulse that would have fired.

## Test plan
Parameters CNT_W=8, STUCK_LIMIT=4, TOGGLE_RUN=3.
- Reset then enable, q_in=0 for 2 cycles, then q_in=1 → no pulse on the INIT cycle; rise=1 for exactly one cycle; edge_count=1; q_level=1.
- Hold q_in=1 for 4 more enabled cycles → stuck=1 after the 4th. Then q_in=0 → fall=1, stuck=0, edge_count=2.
- q_in alternating every cycle for 5 cycles (JK toggle) → rise and fall pulses alternate every cycle; toggling=1 from the 3rd transition; edge_count increases by 5. Then hold q_in → toggling=0 at the next edge.
- enable=0 while q_in goes 0→1, then enable=1 → no pulse while disabled; one rise on re-enable; counters frozen during disable.
- clear=1 coincident with a q_in change → no pulse; edge_count=0; stuck=toggling=0; state INIT. The next enabled cycle only re-initializes.
- Force 260 transitions → edge_count saturates at 255; pulses continue. Then reset mid-toggle → all outputs 0 the next cycle.

Source files
------------

// File: rtl/jk_q_edge_monitor.sv
// jk_q_edge_monitor: watches the Q output of a JK flip-flop on the same clock.
// It reports each rising and falling transition as a one-cycle pulse.
// It also keeps a saturating transition count.
// It flags a stuck output after STUCK_LIMIT idle cycles.
// It flags toggle mode after TOGGLE_RUN back-to-back transitions.
// All outputs are registered.
module jk_q_edge_monitor #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 4,
  parameter int TOGGLE_RUN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             q_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count,
  output logic             stuck,
  output logic             toggling,
  output logic             q_level
);

  localparam int RUN_W = $clog2(TOGGLE_RUN + 1);

  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_LIMIT);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(TOGGLE_RUN);

  // INIT means no valid prior sample exists yet.
  // LOW and HIGH track the last sampled level.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] stable_cnt_reg;
  logic [RUN_W-1:0] run_cnt_reg;

  // Next-value helpers for the saturating counters.
  logic             edge_seen;
  logic [CNT_W-1:0] stable_cnt_next;
  logic [RUN_W-1:0] run_cnt_next;

  // Detect a transition against the held level.
  // Compute the saturating successors of both run counters.
  always_comb begin
    edge_seen       = 1'b0;
    stable_cnt_next = stable_cnt_reg;
    run_cnt_next    = run_cnt_reg;
    if (state_reg == LOW) begin
      edge_seen = q_in;
    end else if (state_reg == HIGH) begin
      edge_seen = ~q_in;
    end
    if (stable_cnt_reg != STUCK_MAX) begin
      stable_cnt_next = stable_cnt_reg + 1'b1;
    end
    if (run_cnt_reg != RUN_MAX) begin
      run_cnt_next = run_cnt_reg + 1'b1;
    end
  end

  // FSM plus all registered outputs.
  // Priority order is reset, then clear, then enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= INIT;
      stable_cnt_reg <= '0;
      run_cnt_reg    <= '0;
      rise           <= 1'b0;
      fall           <= 1'b0;
      edge_count     <= '0;
      stuck          <= 1'b0;
      toggling       <= 1'b0;
      q_level        <= 1'b0;
    end else if (clear) begin
      // q_level deliberately holds across a soft clear.
      state_reg      <= INIT;
      stable_cnt_reg <= '0;
      run_cnt_reg    <= '0;
      rise           <= 1'b0;
      fall           <= 1'b0;
      edge_count     <= '0;
      stuck          <= 1'b0;
      toggling       <= 1'b0;
    end else if (!enable) begin
      // Frozen: only the pulses are dropped, so they never stretch.
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (state_reg == INIT) begin
      // The first sample only establishes the reference level.
      rise      <= 1'b0;
      fall      <= 1'b0;
      q_level   <= q_in;
      state_reg <= q_in ? HIGH : LOW;
    end else if (edge_seen) begin
      rise           <= q_in;
      fall           <= ~q_in;
      q_level        <= q_in;
      state_reg      <= q_in ? HIGH : LOW;
      if (edge_count != COUNT_MAX) begin
        edge_count <= edge_count + 1'b1;
      end
      stable_cnt_reg <= '0;
      stuck          <= 1'b0;
      run_cnt_reg    <= run_cnt_next;
      toggling       <= (run_cnt_next == RUN_MAX);
    end else begin
      rise           <= 1'b0;
      fall           <= 1'b0;
      run_cnt_reg    <= '0;
      toggling       <= 1'b0;
      stable_cnt_reg <= stable_cnt_next;
      stuck          <= stuck | (stable_cnt_next == STUCK_MAX);
    end
  end

endmodule
